// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if -- bundle of the request, response and RAM-side signals
// of the load/store controller.
//
//   Request  : req_valid, req_ready, req_write, req_addr, req_wdata
//   Response : rsp_valid, rsp_ready, rsp_rdata
//   RAM side : mem_write, mem_addr, mem_data_in, mem_data_out
//
// Handshake rule for both the request and the response channel: the
// producer raises valid and holds its payload; a transfer happens on
// the rising clock edge where valid and ready are both 1.
//
// Modports:
//   slave  - the controller (accepts requests, drives responses and RAM).
//   master - the environment (requester plus RAM model).
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  rsp_ready, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata,
        output mem_write, mem_addr, mem_data_in
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output rsp_ready, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata,
        input  mem_write, mem_addr, mem_data_in
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl -- single-outstanding load/store controller in front of a
// synchronous-read RAM.
//
// Ports:
//   clk          - clock, all state changes on its rising edge
//   reset        - synchronous active-high reset
//   bus          - lsu_mem_ctrl_if.slave (request, response, RAM signals)
//   wr_count     - saturating count of completed stores
//   rd_count     - saturating count of completed loads
//   dbg_state_o  - current FSM state, for observation only
//
// Flow: IDLE accepts one request (req_ready=1 only there). A store goes
// through WRITE (one-cycle RAM write strobe), a load through READ_WAIT
// (address presented) and READ_CAP (RAM data arrives and is captured).
// Both end in RESP, which holds rsp_valid until rsp_ready, then returns
// to IDLE. All outputs are registers.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    lsu_mem_ctrl_if.slave        bus,
    output logic [7:0]           wr_count,
    output logic [7:0]           rd_count,
    output logic [2:0]           dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_WAIT = 3'd2,
        READ_CAP  = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t            state_q;
    logic              write_q;      // kind of the access in flight
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;   // doubles as the latched request address
    logic [DATA_W-1:0] mem_data_in_q;// doubles as the latched store data
    logic [7:0]        wr_cnt_q;
    logic [7:0]        rd_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            write_q       <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            wr_cnt_q      <= 8'd0;
            rd_cnt_q      <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        write_q     <= bus.req_write;
                        mem_addr_q  <= bus.req_addr;
                        req_ready_q <= 1'b0;
                        if (bus.req_write) begin
                            mem_write_q   <= 1'b1;
                            mem_data_in_q <= bus.req_wdata;
                            // Store acknowledges carry zero data; clearing it
                            // now keeps it stable for the whole response.
                            rsp_rdata_q   <= '0;
                            state_q       <= WRITE;
                        end else begin
                            state_q <= READ_WAIT;
                        end
                    end
                end
                WRITE: begin
                    mem_write_q <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                READ_WAIT: begin
                    // RAM sees the address this cycle; data is valid next cycle.
                    state_q <= READ_CAP;
                end
                READ_CAP: begin
                    rsp_rdata_q <= bus.mem_data_out;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                        if (write_q) begin
                            if (wr_cnt_q != 8'hFF) wr_cnt_q <= wr_cnt_q + 8'd1;
                        end else begin
                            if (rd_cnt_q != 8'hFF) rd_cnt_q <= rd_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_data_in = mem_data_in_q;
    assign wr_count        = wr_cnt_q;
    assign rd_count        = rd_cnt_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl -- bench for lsu_mem_ctrl: a RAM model on the memory
// side, a transaction-level reference model, a per-cycle compare process
// and directed plus random accesses.
module tb_lsu_mem_ctrl;
    localparam int AW = 2;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wr_count;
    logic [7:0] rd_count;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    lsu_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    lsu_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .wr_count    (wr_count),
        .rd_count    (rd_count),
        .dbg_state_o (dbg_state)
    );

    // ---------------- RAM: synchronous write, one-cycle read ----------------
    logic [DW-1:0] ram [4] = '{default: '0};
    always @(posedge clk) begin
        if (bus.mem_write) ram[bus.mem_addr] <= bus.mem_data_in;
        bus.mem_data_out <= ram[bus.mem_addr];
    end

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // ---------------- reference model ----------------
    // One access at a time. A store shows its write strobe in the cycle after
    // the accepting edge and its response the cycle after that; a load shows
    // its response two cycles after the accepting edge.
    logic [DW-1:0] m_mem [4] = '{default: '0};
    logic [DW-1:0] exp_q [$];
    int            m_wr = 0, m_rd = 0;
    bit            m_busy = 0, m_store = 0;
    int            m_t0 = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    int            cyc = 0;
    int            hs_cnt = 0, acc_cnt = 0;
    bit            started = 0;

    function automatic bit exp_rsp_valid();
        return m_busy && (cyc >= m_t0 + (m_store ? 1 : 2));
    endfunction

    always @(posedge clk) begin
        bit v_now;
        v_now = exp_rsp_valid();
        cyc++;
        started = 1;
        if (reset) begin
            m_busy  = 0;
            m_wr    = 0;
            m_rd    = 0;
            m_addr  = '0;
            m_wdata = '0;
            exp_q.delete();
        end else if (m_busy) begin
            if (v_now && bus.rsp_ready) begin
                void'(exp_q.pop_front());
                if (m_store) m_wr = (m_wr < 255) ? m_wr + 1 : 255;
                else         m_rd = (m_rd < 255) ? m_rd + 1 : 255;
                m_busy = 0;
                acc_cnt++;
            end
        end else if (bus.req_valid) begin
            m_busy  = 1;
            m_store = bus.req_write;
            m_t0    = cyc;
            m_addr  = bus.req_addr;
            if (bus.req_write) begin
                m_wdata         = bus.req_wdata;
                m_mem[m_addr]   = bus.req_wdata;
                exp_q.push_back('0);
            end else begin
                exp_q.push_back(m_mem[m_addr]);
            end
            hs_cnt++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            bit ev;
            ev = exp_rsp_valid();
            check("req_ready",   {31'd0, bus.req_ready}, {31'd0, !m_busy});
            check("mem_write",   {31'd0, bus.mem_write}, {31'd0, (m_busy && m_store && cyc == m_t0)});
            check("mem_addr",    32'(bus.mem_addr), 32'(m_addr));
            check("mem_data_in", 32'(bus.mem_data_in), 32'(m_wdata));
            check("rsp_valid",   {31'd0, bus.rsp_valid}, {31'd0, ev});
            if (ev) check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_q[0]));
            check("wr_count", 32'(wr_count), 32'(m_wr));
            check("rd_count", 32'(rd_count), 32'(m_rd));
        end
    end

    // Write-strobe observer for the directed scenarios.
    int            wr_pulses = 0;
    logic [AW-1:0] last_w_addr = '0;
    logic [DW-1:0] last_w_data = '0;
    always @(negedge clk) begin
        if (bus.mem_write) begin
            wr_pulses++;
            last_w_addr = bus.mem_addr;
            last_w_data = bus.mem_data_in;
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge after the response transfer.
    task automatic do_access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int stall, output int lat, output logic [DW-1:0] rdata);
        int h0, a0, n;
        h0 = hs_cnt;
        lat = 0;
        rdata = '0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = (stall == 0);
        n = 0;
        while (hs_cnt == h0 && n < 20) begin @(negedge clk); n++; end
        if (hs_cnt == h0) begin
            fail_now("req_handshake");
            bus.req_valid = 1'b0;
            return;
        end
        // Access is in flight: scramble the request lines, they must be ignored.
        a0 = acc_cnt;
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = AW'($urandom_range(0, 3));
        bus.req_wdata = DW'($urandom_range(0, 255));
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
        if (!bus.rsp_valid) begin
            fail_now("rsp_valid_wait");
            bus.req_valid = 1'b0;
            return;
        end
        lat   = n + 1;
        rdata = bus.rsp_rdata;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("hold_rsp_rdata", 32'(bus.rsp_rdata), 32'(rdata));
            check("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        n = 0;
        while (acc_cnt == a0 && n < 20) begin @(negedge clk); n++; end
        if (acc_cnt == a0) fail_now("rsp_transfer");
        bus.req_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"},   {31'd0, bus.req_ready}, 32'd1);
        check({tag, "_rsp_valid"},   {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_rsp_rdata"},   32'(bus.rsp_rdata), 32'd0);
        check({tag, "_mem_write"},   {31'd0, bus.mem_write}, 32'd0);
        check({tag, "_mem_addr"},    32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_data_in"}, 32'(bus.mem_data_in), 32'd0);
        check({tag, "_wr_count"},    32'(wr_count), 32'd0);
        check({tag, "_rd_count"},    32'(rd_count), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int            lat, p0, h0, n;
        logic [DW-1:0] rd;
        bit            wr;

        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of a store: access aborted, no count update.
        h0 = hs_cnt;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 2'd2;
        bus.req_wdata = 8'h55;
        n = 0;
        while (hs_cnt == h0 && n < 20) begin @(negedge clk); n++; end
        if (hs_cnt == h0) fail_now("rst_mid_handshake");
        check("rst_mid_in_write", {31'd0, bus.mem_write}, 32'd1);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("rst_mid");
        repeat (3) @(negedge clk);
        check("rst_mid_wr_count_after", 32'(wr_count), 32'd0);

        // Store addr 1 = 0x3C.
        p0 = wr_pulses;
        do_access(1'b1, 2'd1, 8'h3C, 0, lat, rd);
        check("st1_latency", 32'(lat), 32'd2);
        check("st1_pulses", 32'(wr_pulses - p0), 32'd1);
        check("st1_w_addr", 32'(last_w_addr), 32'd1);
        check("st1_w_data", 32'(last_w_data), 32'h3C);
        check("st1_ack_data", 32'(rd), 32'd0);
        check("st1_wr_count", 32'(wr_count), 32'd1);

        // Load addr 1.
        p0 = wr_pulses;
        do_access(1'b0, 2'd1, 8'h00, 0, lat, rd);
        check("ld1_latency", 32'(lat), 32'd3);
        check("ld1_rdata", 32'(rd), 32'h3C);
        check("ld1_no_write", 32'(wr_pulses - p0), 32'd0);
        check("ld1_rd_count", 32'(rd_count), 32'd1);

        // Store addr 3 = 0xF0, then load 3 and 1.
        do_access(1'b1, 2'd3, 8'hF0, 0, lat, rd);
        do_access(1'b0, 2'd3, 8'h00, 0, lat, rd);
        check("ld3_rdata", 32'(rd), 32'hF0);
        do_access(1'b0, 2'd1, 8'h00, 0, lat, rd);
        check("ld1b_rdata", 32'(rd), 32'h3C);

        // Load with the response stalled for 5 cycles.
        do_access(1'b0, 2'd3, 8'h00, 5, lat, rd);
        check("stall_rdata", 32'(rd), 32'hF0);
        check("stall_rd_count", 32'(rd_count), 32'd4);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            do_access(wr, AW'($urandom_range(0, 3)), DW'($urandom_range(0, 255)),
                      int'($urandom_range(0, 3)), lat, rd);
            check("rnd_latency", 32'(lat), wr ? 32'd2 : 32'd3);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // 260 stores: the store counter must stop at 255.
        for (int i = 0; i < 260; i++) begin
            do_access(1'b1, AW'($urandom_range(0, 3)), DW'($urandom_range(0, 255)), 0, lat, rd);
        end
        check("sat_wr_count", 32'(wr_count), 32'd255);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
